nbit_seq_addsub: RTL

NBIT_SEQ_ADDSUB -- requirements
Module: nbit_seq_addsub

---
 rtl/nbit_seq_addsub.sv | 95 +++++++++
 1 files changed

// File: rtl/nbit_seq_addsub.sv
// nbit_seq_addsub: sequential N-bit adder/subtractor that ripples K bits per RUN cycle.
// Operands are latched on start, so input changes during RUN cannot disturb the result.
module nbit_seq_addsub #(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);
    localparam int M  = N / K;
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_s;
    logic [N-1:0]   w_s_nxt;
    logic           r_c;
    logic [IW-1:0]  r_idx;
    logic           r_cout;
    logic           r_ovf;
    logic           r_zero;
    logic [K-1:0]   w_ach;
    logic [K-1:0]   w_bch;
    logic [K:0]     w_sum;
    logic           w_last;

    assign w_ach  = r_a[int'(r_idx)*K +: K];
    assign w_bch  = r_b[int'(r_idx)*K +: K];
    assign w_sum  = {1'b0, w_ach} + {1'b0, w_bch} + (K+1)'(r_c);
    assign w_last = (r_idx == IW'(M - 1));

    always_comb begin
        w_s_nxt = r_s;
        w_s_nxt[int'(r_idx)*K +: K] = w_sum[K-1:0];
    end

    always_comb begin
        w_state_nxt = (r_state == IDLE) ? (start ? RUN : IDLE) :
                      (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_idx   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && start) begin
                r_a   <= a;
                r_b   <= b ^ {N{sub}};
                r_c   <= sub | cin;
                r_idx <= '0;
            end else if (r_state == RUN) begin
                r_s   <= w_s_nxt;
                r_c   <= w_sum[K];
                r_idx <= r_idx + IW'(1);
                // carry into the MSB is recovered as a^b^sum of that bit
                if (w_last) begin
                    r_cout <= w_sum[K];
                    r_ovf  <= w_ach[K-1] ^ w_bch[K-1] ^ w_sum[K-1] ^ w_sum[K];
                    r_zero <= (w_s_nxt == '0);
                end
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;
endmodule
